// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Operand/result bus of the sequential divider: valid/ready request, pulsed result.
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data1;
  logic [WIDTH-1:0] i_data2;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [WIDTH-1:0] o_rem;
  logic             o_err;

  modport master (
    output i_valid, i_data1, i_data2,
    input  o_ready, o_valid, o_data, o_rem, o_err
  );

  modport slave (
    input  i_valid, i_data1, i_data2,
    output o_ready, o_valid, o_data, o_rem, o_err
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] shifted_low;

  assign shifted     = {r_in, bit_in};
  assign shifted_low = {r_in[WIDTH-2:0], bit_in};
  assign q_bit       = (shifted >= {1'b0, divisor});
  // The true difference always fits WIDTH bits, so modular subtraction is exact.
  assign r_out       = q_bit ? (shifted_low - divisor) : shifted_low;

endmodule

// File: rtl/div_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional round-to-nearest of the quotient when DIV_ROUND_EN is defined.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic      sys_clk,
  input  logic      sys_rst_n,
  div_seq_if.slave  bus
);

  localparam int CNT_W = clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic [WIDTH-1:0] o_rem_q, o_rem_d;
  logic             o_err_q, o_err_d;

  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH-1:0] quot;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

`ifdef DIV_ROUND_EN
  logic round_up;
  assign round_up = !zero_q && ({r_q, 1'b0} >= {1'b0, dvs_q});
  assign quot     = (round_up && !(&dvd_q)) ? (dvd_q + 1'b1) : dvd_q;
`else
  assign quot     = dvd_q;
`endif

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;
    o_rem_d   = o_rem_q;
    o_err_d   = o_err_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          dvd_d   = bus.i_data1;
          dvs_d   = bus.i_data2;
          zero_d  = (bus.i_data2 == '0);
          r_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Quotient bits shift into the vacated low end of the dividend register.
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_data_d  = quot;
        o_rem_d   = r_q;
        o_err_d   = zero_q;
        o_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_rem_q   <= '0;
      o_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_rem_q   <= o_rem_d;
      o_err_q   <= o_err_d;
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_rem   = o_rem_q;
  assign bus.o_err   = o_err_q;

endmodule
